// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, default reset PC and fetch FSM state encoding
package fetch_pkg;
  localparam int INST_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DRAIN} fetch_state_e;
endpackage

// File: rtl/sat_updown_counter.sv
// sat_updown_counter: saturating up/down counter with load (clk, rst, inc, dec, load, load_val -> count); over/underflow asserted
module sat_updown_counter #(
  parameter int W = 4,
  parameter int MAX = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] MAXV = W'(MAX);
  logic up, dn;
  always_comb begin
    up = inc && !dec && count != MAXV;
    dn = dec && !inc && count != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= W'(RST_VAL);
    end else begin
      count <= load ? load_val : up ? count + W'(1) : dn ? count - W'(1) : count;
      if (!load) begin
        assert (!(inc && !dec && count == MAXV)) else $error("sat_updown_counter overflow");
        assert (!(dec && !inc && count == '0)) else $error("sat_updown_counter underflow");
      end
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC owner; issues I-cache requests (icache_req_*) within IQ credits/outstanding limits, forwards responses to iq_wr_*, flushes on redirect_*
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int IQ_DEPTH = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  icache_req_valid,
  output logic [ADDR_WIDTH-1:0] icache_req_pc,
  input  logic                  icache_req_ready,
  input  logic                  icache_resp_valid,
  input  logic [ADDR_WIDTH-1:0] icache_resp_pc,
  input  logic [INST_WIDTH-1:0] icache_resp_data,
  output logic                  iq_wr_valid,
  output logic [ADDR_WIDTH-1:0] iq_wr_pc,
  output logic [INST_WIDTH-1:0] iq_wr_data,
  output logic                  iq_flush,
  input  logic                  iq_pop
);
  localparam int CW = $clog2(IQ_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] C_MAX = CW'(IQ_DEPTH);
  localparam logic [OW-1:0] O_MAX = OW'(MAX_OUTSTANDING);
  fetch_state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0] credits;
  logic [OW-1:0] outstanding, out_nxt;
  logic redir, accept;
  // A redirect arriving before the first fetch has nothing to cancel, so it is ignored in RESET.
  always_comb begin
    redir = redirect_valid && state != S_RESET;
    icache_req_valid = state == S_FETCH && credits != '0 && outstanding < O_MAX && !redir;
    accept = icache_req_valid && icache_req_ready;
    icache_req_pc = pc;
    iq_wr_valid = icache_resp_valid && state == S_FETCH && !redir;
    iq_wr_pc = icache_resp_pc;
    iq_wr_data = icache_resp_data;
    iq_flush = redir;
    out_nxt = outstanding + OW'(accept) - OW'(icache_resp_valid);
    state_nxt = state == S_RESET ? S_FETCH :
                (state == S_FETCH && !redir) ? S_FETCH :
                out_nxt == '0 ? S_FETCH : S_DRAIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
      pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc <= redir ? redirect_pc : accept ? pc + 32'd4 : pc;
    end
  end
  sat_updown_counter #(.W(CW), .MAX(IQ_DEPTH), .RST_VAL(IQ_DEPTH)) u_credits (
    .clk(clk), .rst(rst), .inc(iq_pop && !redir), .dec(accept),
    .load(redir), .load_val(C_MAX), .count(credits)
  );
  sat_updown_counter #(.W(OW), .MAX(MAX_OUTSTANDING), .RST_VAL(0)) u_outstanding (
    .clk(clk), .rst(rst), .inc(accept), .dec(icache_resp_valid),
    .load(1'b0), .load_val('0), .count(outstanding)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: self-checking bench with I-cache model, write scoreboard, vector table and corner sequences
module tb_fetch_sequencer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, redirect_valid = 0, icache_req_ready = 0, icache_resp_valid = 0, iq_pop = 0;
  logic [31:0] redirect_pc = 0, icache_resp_pc = 0, icache_resp_data = 0;
  logic icache_req_valid, iq_wr_valid, iq_flush;
  logic [31:0] icache_req_pc, iq_wr_pc, iq_wr_data;

  fetch_sequencer #(.RESET_PC(32'h0), .IQ_DEPTH(8), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .icache_req_valid(icache_req_valid), .icache_req_pc(icache_req_pc), .icache_req_ready(icache_req_ready),
    .icache_resp_valid(icache_resp_valid), .icache_resp_pc(icache_resp_pc), .icache_resp_data(icache_resp_data),
    .iq_wr_valid(iq_wr_valid), .iq_wr_pc(iq_wr_pc), .iq_wr_data(iq_wr_data),
    .iq_flush(iq_flush), .iq_pop(iq_pop)
  );

  typedef struct {logic [31:0] pc; int due;} pend_t;
  typedef struct {logic redir, ready, resp, pop, e_req, e_wr, e_flush, e_nreq; logic [31:0] e_npc;} vec_t;
  pend_t pend[$];
  logic [31:0] exp_q[$], acc_pcs[$];
  logic [31:0] exp_pc = 0, s_req_pc;
  logic s_req, s_wr, s_flush;
  int occ = 0, acc_cnt = 0, wr_cnt = 0, cyc = 0, lat = 1;
  bit auto_pop = 0, manual = 0;
  int tests = 0, fails = 0;

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    return pc ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    pend_t p;
    logic [31:0] e;
    @(negedge clk);
    s_req = icache_req_valid; s_wr = iq_wr_valid; s_flush = iq_flush; s_req_pc = icache_req_pc;
    if (!rst) begin
      chk("flush", {31'd0, iq_flush}, {31'd0, redirect_valid});
      if (redirect_valid) begin
        chk("redir_req_withdrawn", {31'd0, icache_req_valid}, 0);
        chk("redir_wr_dropped", {31'd0, iq_wr_valid}, 0);
        exp_q.delete();
        exp_pc = redirect_pc;
        occ = 0;
      end else begin
        if (iq_wr_valid) begin
          if (exp_q.size() == 0) chk("wr_unexpected", {31'd0, iq_wr_valid}, 0);
          else begin
            e = exp_q.pop_front();
            chk("wr_pc", iq_wr_pc, e);
            chk("wr_data", iq_wr_data, inst_of(e));
          end
          wr_cnt++;
          occ++;
          chk("iq_not_overrun", {31'd0, occ <= 8}, 1);
        end
        if (icache_req_valid) chk("req_pc", icache_req_pc, exp_pc);
        if (icache_req_valid && icache_req_ready) begin
          pend.push_back('{exp_pc, cyc + lat});
          exp_q.push_back(exp_pc);
          acc_pcs.push_back(icache_req_pc);
          exp_pc += 4;
          acc_cnt++;
        end
        if (iq_pop) occ--;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect_valid = 0;
    icache_resp_valid = 0;
    if (!manual && pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      icache_resp_valid = 1;
      icache_resp_pc = p.pc;
      icache_resp_data = inst_of(p.pc);
    end
    manual = 0;
    iq_pop = auto_pop && occ > 0;
  endtask

  task automatic do_reset();
    rst = 1; redirect_valid = 0; icache_req_ready = 0; auto_pop = 0;
    pend.delete(); exp_q.delete(); acc_pcs.delete();
    cycle();
    cycle();
    chk("rst_req_valid", {31'd0, s_req}, 0);
    chk("rst_wr_valid", {31'd0, s_wr}, 0);
    chk("rst_flush", {31'd0, s_flush}, 0);
    chk("rst_req_pc", s_req_pc, 32'h0);
    rst = 0; exp_pc = 0; occ = 0; acc_cnt = 0; wr_cnt = 0;
    cycle();
    chk("reset_state_idle", {31'd0, s_req}, 0);
  endtask

  task automatic wait_req(output int n);
    for (n = 1; n <= 20; n++) begin
      cycle();
      if (s_req) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int n, a0, n0;
    logic [7:0] pat;
    // redir ready resp pop | req wr flush | next req, next pc   (one request to pc 0 already outstanding)
    vecs[0] = '{0, 0, 0, 0, 1, 0, 0, 1, 32'h4};
    vecs[1] = '{0, 1, 0, 0, 1, 0, 0, 1, 32'h8};
    vecs[2] = '{0, 0, 1, 0, 1, 1, 0, 1, 32'h4};
    vecs[3] = '{1, 1, 1, 1, 0, 0, 1, 1, 32'h100};
    vecs[4] = '{1, 0, 0, 0, 0, 0, 1, 0, 32'h100};
    vecs[5] = '{0, 1, 1, 1, 1, 1, 0, 1, 32'h8};
    vecs[6] = '{0, 0, 0, 1, 1, 0, 0, 1, 32'h4};
    for (int i = 0; i < 7; i++) begin
      lat = 1000;
      do_reset();
      icache_req_ready = 1;
      cycle();
      icache_req_ready = vecs[i].ready; redirect_valid = vecs[i].redir; redirect_pc = 32'h100;
      iq_pop = vecs[i].pop; manual = 1; icache_resp_valid = vecs[i].resp;
      icache_resp_pc = 32'h0; icache_resp_data = inst_of(32'h0);
      cycle();
      chk($sformatf("v%0d_req_valid", i), {31'd0, s_req}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_wr_valid", i), {31'd0, s_wr}, {31'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_flush", i), {31'd0, s_flush}, {31'd0, vecs[i].e_flush});
      icache_req_ready = 0;
      cycle();
      chk($sformatf("v%0d_next_req_valid", i), {31'd0, s_req}, {31'd0, vecs[i].e_nreq});
      chk($sformatf("v%0d_next_pc", i), s_req_pc, vecs[i].e_npc);
    end

    lat = 1;
    do_reset();
    icache_req_ready = 1;
    cycle();
    chk("first_req_after_reset", {31'd0, s_req}, 1);
    chk("first_req_pc", s_req_pc, 32'h0);
    repeat (13) cycle();
    chk("fill_accepts", acc_cnt, 8);
    chk("fill_writes", wr_cnt, 8);
    chk("fill_req_stalled", {31'd0, s_req}, 0);
    chk("fill_pc_held", s_req_pc, 32'h20);

    auto_pop = 1;
    iq_pop = occ > 0;
    n0 = acc_cnt;
    repeat (40) cycle();
    chk("steady_rate", {31'd0, (acc_cnt - n0) >= 38}, 1);

    lat = 5;
    do_reset();
    auto_pop = 1;
    icache_req_ready = 1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      pat[7-k] = s_req;
    end
    chk("outstanding_cap", {24'd0, pat}, 32'h0000_00F3);

    lat = 5;
    do_reset();
    icache_req_ready = 1;
    repeat (3) cycle();
    redirect_valid = 1; redirect_pc = 32'h100;
    cycle();
    chk("drain_flush", {31'd0, s_flush}, 1);
    chk("drain_withdrawn", {31'd0, s_req}, 0);
    a0 = acc_cnt;
    wait_req(n);
    chk("drain_restart_delay", n, 5);
    chk("drain_restart_pc", s_req_pc, 32'h100);
    chk("drain_stale_dropped", wr_cnt, 0);
    repeat (40) cycle();
    chk("drain_credits_full", acc_cnt - a0, 8);
    chk("drain_writes", wr_cnt, 8);

    lat = 5;
    do_reset();
    icache_req_ready = 1;
    repeat (3) cycle();
    redirect_valid = 1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1; redirect_pc = 32'h200;
    cycle();
    wait_req(n);
    chk("double_redir_delay", n, 4);
    chk("double_redir_pc", s_req_pc, 32'h200);
    chk("double_redir_stale", wr_cnt, 0);

    lat = 1;
    do_reset();
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    cycle();
    icache_req_ready = 1;
    repeat (4) cycle();
    chk("wrap_pc0", acc_pcs[0], 32'hFFFF_FFF8);
    chk("wrap_pc1", acc_pcs[1], 32'hFFFF_FFFC);
    chk("wrap_pc2", acc_pcs[2], 32'h0000_0000);
    chk("wrap_pc3", acc_pcs[3], 32'h0000_0004);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
